// File: rtl/othello_vga_pkg.sv
// Shared widths, requester indices and arbiter state encoding for the othello VGA pixel path.
package othello_vga_pkg;

    localparam int unsigned X_W      = 8;
    localparam int unsigned Y_W      = 7;
    localparam int unsigned COLOUR_W = 18;

    localparam int unsigned REQ_CURSOR = 0;
    localparam int unsigned REQ_REDRAW = 1;

    typedef enum logic {
        ARB_IDLE,
        ARB_OWN
    } arb_state_t;

endpackage

// File: rtl/plot_rr_picker.sv
// Combinational round-robin pick: first asserted req at or after ptr, wrapping to index 0.
module plot_rr_picker #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic               any
);

    logic [PTR_W-1:0] idx;
    logic             found;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = PTR_W'((32'(ptr) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/vga_plot_arbiter.sv
// Round-robin, burst-lockable arbiter sharing the vga_adapter pixel port among NUM_REQ producers.
// Optional per-requester accepted-pixel counters on pix_count when PLOT_ARB_COUNT_EN is defined.
module vga_plot_arbiter
    import othello_vga_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 2,
    parameter int unsigned MAX_BURST = 64
) (
    input  logic                         clock,
    input  logic                         resetn,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ-1:0]           lock,
    input  logic [NUM_REQ*X_W-1:0]       x_in,
    input  logic [NUM_REQ*Y_W-1:0]       y_in,
    input  logic [NUM_REQ*COLOUR_W-1:0]  colour_in,
    output logic [NUM_REQ-1:0]           ack,
    output logic [NUM_REQ-1:0]           grant,
    output logic                         plot,
    output logic [X_W-1:0]               x,
    output logic [Y_W-1:0]               y,
    output logic [COLOUR_W-1:0]          colour,
    output logic                         busy
`ifdef PLOT_ARB_COUNT_EN
    ,
    output logic [NUM_REQ*16-1:0]        pix_count
`endif
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    arb_state_t          state;
    logic [PTR_W-1:0]    rr_ptr;
    logic [CNT_W-1:0]    count;

    logic [NUM_REQ-1:0]  winner;
    logic                any;

    logic                own_req;
    logic                own_lock;
    logic [PTR_W-1:0]    own_idx;
    logic [X_W-1:0]      own_x;
    logic [Y_W-1:0]      own_y;
    logic [COLOUR_W-1:0] own_colour;
    logic                own_ack;
    logic                burst_done;
    logic [PTR_W-1:0]    next_ptr;

    plot_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .req    (req),
        .ptr    (rr_ptr),
        .winner (winner),
        .any    (any)
    );

    // grant is one-hot in OWN, so this selects exactly the owner's lanes
    always_comb begin
        own_req    = 1'b0;
        own_lock   = 1'b0;
        own_idx    = '0;
        own_x      = '0;
        own_y      = '0;
        own_colour = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                own_req    = req[i];
                own_lock   = lock[i];
                own_idx    = PTR_W'(i);
                own_x      = x_in[i*X_W +: X_W];
                own_y      = y_in[i*Y_W +: Y_W];
                own_colour = colour_in[i*COLOUR_W +: COLOUR_W];
            end
        end
    end

    assign ack        = (state == ARB_OWN) ? (grant & req) : '0;
    assign own_ack    = (state == ARB_OWN) && own_req;
    assign burst_done = (count == CNT_W'(MAX_BURST - 1));
    assign next_ptr   = (own_idx == PTR_W'(NUM_REQ - 1)) ? '0 : own_idx + PTR_W'(1);
    assign busy       = (state == ARB_OWN);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state  <= ARB_IDLE;
            grant  <= '0;
            rr_ptr <= '0;
            count  <= '0;
            plot   <= 1'b0;
            x      <= '0;
            y      <= '0;
            colour <= '0;
`ifdef PLOT_ARB_COUNT_EN
            pix_count <= '0;
`endif
        end else begin
            plot <= 1'b0;
            unique case (state)
                ARB_IDLE: begin
                    if (any) begin
                        grant <= winner;
                        count <= '0;
                        state <= ARB_OWN;
                    end
                end
                ARB_OWN: begin
                    if (own_ack) begin
                        plot   <= 1'b1;
                        x      <= own_x;
                        y      <= own_y;
                        colour <= own_colour;
                        count  <= count + CNT_W'(1);
                    end
                    // the burst cap overrides lock; the capping pixel is still plotted
                    if ((own_ack && burst_done) || (!own_req && !own_lock)) begin
                        state  <= ARB_IDLE;
                        grant  <= '0;
                        rr_ptr <= next_ptr;
                    end
                end
            endcase
`ifdef PLOT_ARB_COUNT_EN
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (ack[i]) begin
                    pix_count[i*16 +: 16] <= pix_count[i*16 +: 16] + 16'd1;
                end
            end
`endif
        end
    end

endmodule
